// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: state encoding, default timing parameters and the counter-width helper
// shared by the PLL reset sequencer and the downstream GPIO test block.
package pll_seq_pkg;
  typedef enum logic [2:0] {
    RST_PLL   = 3'd0,
    WAIT_LOCK = 3'd1,
    QUALIFY   = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;
  localparam int unsigned DEF_RST_PULSE_CYC    = 16;
  localparam int unsigned DEF_LOCK_STABLE_CYC  = 1024;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYC = 65536;
  localparam int unsigned DEF_MAX_RETRY        = 7;
  // Bits needed to hold n-1, never less than one.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pll_reset_seq_if.sv
// pll_reset_seq_if: PLL-side and status signals of the reset sequencer.
//   pll_LOCKED     PLL lock indication (async to clk)
//   pll_RSTN       active-low PLL reset
//   sys_rstn/run   downstream release, high only in RUN
//   fault          high only in FAULT
//   state          current state encoding
//   retry_cnt      retries consumed in the current bring-up
//   lock_loss_cnt  saturating count of lock losses in RUN
interface pll_reset_seq_if;
  logic       pll_LOCKED;
  logic       pll_RSTN;
  logic       sys_rstn;
  logic       run;
  logic       fault;
  logic [2:0] state;
  logic [3:0] retry_cnt;
  logic [7:0] lock_loss_cnt;
  modport master (
    input  pll_LOCKED,
    output pll_RSTN, sys_rstn, run, fault, state, retry_cnt, lock_loss_cnt
  );
  modport slave (
    output pll_LOCKED,
    input  pll_RSTN, sys_rstn, run, fault, state, retry_cnt, lock_loss_cnt
  );
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer, synchronous active-low reset to 0.
//   clk, resetn  destination clock and reset
//   d            asynchronous input
//   q            synchronized output
module sync_2ff (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);
  logic s1;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end
endmodule

// File: rtl/pll_reset_seq.sv
// pll_reset_seq: PLL reset pulse, lock wait with timeout/retry, lock qualification and
// system reset release.
//   clk     system clock
//   resetn  synchronous active-low reset
//   bus     pll_reset_seq_if.master (PLL lock in; PLL reset, system reset and status out)
module pll_reset_seq
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
  parameter int unsigned LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
  parameter int unsigned LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
  parameter int unsigned MAX_RETRY        = DEF_MAX_RETRY
) (
  input logic            clk,
  input logic            resetn,
  pll_reset_seq_if.master bus
);
  localparam int unsigned MAX_A   = (RST_PULSE_CYC > LOCK_STABLE_CYC) ? RST_PULSE_CYC : LOCK_STABLE_CYC;
  localparam int unsigned MAX_CYC = (MAX_A > LOCK_TIMEOUT_CYC) ? MAX_A : LOCK_TIMEOUT_CYC;
  localparam int unsigned CW      = cnt_w(MAX_CYC);
  localparam logic [CW-1:0] PULSE_END  = CW'(RST_PULSE_CYC - 1);
  localparam logic [CW-1:0] STABLE_END = CW'(LOCK_STABLE_CYC - 1);
  localparam logic [CW-1:0] TMO_END    = CW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [3:0]    RETRY_MAX  = 4'(MAX_RETRY);
  state_t        st, nxt;
  logic [CW-1:0] cnt;
  logic [3:0]    retry;
  logic [7:0]    loss;
  logic          lock_s;
  logic          tmo;
  logic          retry_inc;
  logic          lost;
  sync_2ff u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (bus.pll_LOCKED),
    .q      (lock_s)
  );
  // Lock is checked before the timeout so a lock in the final window cycle wins.
  assign tmo       = (st == WAIT_LOCK) && !lock_s && (cnt == TMO_END);
  assign retry_inc = tmo && (retry != RETRY_MAX);
  assign lost      = (st == RUN) && !lock_s;
  always_comb begin
    nxt = st;
    case (st)
      RST_PLL:   nxt = (cnt == PULSE_END) ? WAIT_LOCK : RST_PLL;
      WAIT_LOCK: nxt = lock_s ? QUALIFY : !tmo ? WAIT_LOCK : retry_inc ? RST_PLL : FAULT;
      QUALIFY:   nxt = !lock_s ? WAIT_LOCK : (cnt == STABLE_END) ? RUN : QUALIFY;
      RUN:       nxt = lock_s ? RUN : RST_PLL;
      FAULT:     nxt = FAULT;
      default:   nxt = RST_PLL;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      st    <= RST_PLL;
      cnt   <= '0;
      retry <= '0;
      loss  <= '0;
    end else begin
      st    <= nxt;
      cnt   <= (nxt != st) ? '0 : cnt + 1'b1;
      retry <= lost ? 4'd0 : retry_inc ? retry + 4'd1 : retry;
      loss  <= (lost && loss != 8'hFF) ? loss + 8'd1 : loss;
    end
  end
  assign bus.pll_RSTN      = (st != RST_PLL);
  assign bus.sys_rstn      = (st == RUN);
  assign bus.run           = (st == RUN);
  assign bus.fault         = (st == FAULT);
  assign bus.state         = st;
  assign bus.retry_cnt     = retry;
  assign bus.lock_loss_cnt = loss;
endmodule

// File: tb/tb_pll_reset_seq.sv
// tb_pll_reset_seq: directed bench for pll_reset_seq with short timing parameters.
module tb_pll_reset_seq;
  logic clk = 1'b0;
  logic resetn;
  int   n_chk = 0;
  int   n_fail = 0;
  int   k;
  pll_reset_seq_if bus ();
  pll_reset_seq #(
    .RST_PULSE_CYC    (4),
    .LOCK_STABLE_CYC  (8),
    .LOCK_TIMEOUT_CYC (32),
    .MAX_RETRY        (2)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic rstn_low_len(output int n);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (bus.pll_RSTN == 1'b0 && n < 200);
  endtask
  task automatic wait_sys(input logic v, output int n);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (bus.sys_rstn != v && n < 200);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, 32'(bus.state), 0);
    chk({tag, "_pll_rstn"}, 32'(bus.pll_RSTN), 0);
    chk({tag, "_sys_rstn"}, 32'(bus.sys_rstn), 0);
    chk({tag, "_run"}, 32'(bus.run), 0);
    chk({tag, "_fault"}, 32'(bus.fault), 0);
    chk({tag, "_retry"}, 32'(bus.retry_cnt), 0);
    chk({tag, "_loss"}, 32'(bus.lock_loss_cnt), 0);
  endtask
  task automatic bring_up(input string tag);
    resetn = 1'b1;
    rstn_low_len(k);
    chk({tag, "_pll_rstn_len"}, k, 4);
    tick(6);
    bus.pll_LOCKED = 1'b1;
    wait_sys(1'b1, k);
    chk({tag, "_rise_lat"}, k, 11);
    chk({tag, "_run_state"}, 32'(bus.state), 3);
    chk({tag, "_run"}, 32'(bus.run), 1);
    chk({tag, "_retry"}, 32'(bus.retry_cnt), 0);
  endtask
  initial begin
    resetn = 1'b0;
    bus.pll_LOCKED = 1'b0;
    tick(3);
    chk_reset("por");
    bring_up("boot");
    // lock loss in RUN
    bus.pll_LOCKED = 1'b0;
    wait_sys(1'b0, k);
    chk("loss_fall_lat", k, 3);
    chk("loss_state", 32'(bus.state), 0);
    chk("loss_cnt1", 32'(bus.lock_loss_cnt), 1);
    chk("loss_retry", 32'(bus.retry_cnt), 0);
    rstn_low_len(k);
    chk("loss_pll_rstn_len", k, 4);
    // qualify glitch
    bus.pll_LOCKED = 1'b1;
    tick(3);
    chk("glitch_qual", 32'(bus.state), 2);
    tick(5);
    bus.pll_LOCKED = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("glitch_sys_low", 32'(bus.sys_rstn), 0);
    end
    chk("glitch_back_wait", 32'(bus.state), 1);
    bus.pll_LOCKED = 1'b1;
    wait_sys(1'b1, k);
    chk("glitch_requal_lat", k, 11);
    // lock-loss counter saturation: 255 more losses, 256 total
    for (int i = 0; i < 255; i++) begin
      bus.pll_LOCKED = 1'b0;
      tick(7);
      bus.pll_LOCKED = 1'b1;
      tick(11);
      if (i == 0) chk("loss_cnt2", 32'(bus.lock_loss_cnt), 2);
    end
    chk("loss_sat", 32'(bus.lock_loss_cnt), 255);
    chk("loss_sat_run", 32'(bus.run), 1);
    // no lock ever -> retries then FAULT
    resetn = 1'b0;
    bus.pll_LOCKED = 1'b0;
    tick(1);
    chk_reset("rst_run");
    resetn = 1'b1;
    tick(4);
    chk("nl_w0", 32'(bus.state), 1);
    chk("nl_r0", 32'(bus.retry_cnt), 0);
    tick(31);
    chk("nl_w0_end", 32'(bus.state), 1);
    tick(1);
    chk("nl_rst1", 32'(bus.state), 0);
    chk("nl_r1", 32'(bus.retry_cnt), 1);
    rstn_low_len(k);
    chk("nl_pulse1", k, 4);
    tick(32);
    chk("nl_rst2", 32'(bus.state), 0);
    chk("nl_r2", 32'(bus.retry_cnt), 2);
    rstn_low_len(k);
    chk("nl_pulse2", k, 4);
    tick(31);
    chk("nl_w2_end", 32'(bus.state), 1);
    tick(1);
    chk("nl_fault_state", 32'(bus.state), 4);
    chk("nl_fault", 32'(bus.fault), 1);
    chk("nl_fault_pll_rstn", 32'(bus.pll_RSTN), 1);
    chk("nl_fault_sys", 32'(bus.sys_rstn), 0);
    bus.pll_LOCKED = 1'b1;
    tick(20);
    chk("fault_sticky", 32'(bus.fault), 1);
    chk("fault_sticky_state", 32'(bus.state), 4);
    // one-cycle reset during FAULT
    resetn = 1'b0;
    bus.pll_LOCKED = 1'b0;
    tick(1);
    chk_reset("rst_fault");
    bring_up("refault");
    // one-cycle reset during QUALIFY (after one loss so the counter is nonzero)
    bus.pll_LOCKED = 1'b0;
    tick(7);
    chk("q_wait", 32'(bus.state), 1);
    chk("q_loss1", 32'(bus.lock_loss_cnt), 1);
    bus.pll_LOCKED = 1'b1;
    tick(5);
    chk("q_in_qual", 32'(bus.state), 2);
    resetn = 1'b0;
    bus.pll_LOCKED = 1'b0;
    tick(1);
    chk_reset("rst_qual");
    bring_up("requal");
    // lock_s first high in the last WAIT_LOCK cycle: lock beats timeout
    bus.pll_LOCKED = 1'b0;
    tick(7);
    chk("edge_wait", 32'(bus.state), 1);
    tick(29);
    bus.pll_LOCKED = 1'b1;
    tick(2);
    chk("edge_last_wait", 32'(bus.state), 1);
    tick(1);
    chk("edge_qual", 32'(bus.state), 2);
    chk("edge_retry", 32'(bus.retry_cnt), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pll_reset_seq.md
PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 Parameter RST_PULSE_CYC, default 16: number of cycles pll_RSTN is held low per PLL reset attempt (min 1).
REQ-002 Parameter LOCK_STABLE_CYC, default 1024: number of consecutive locked cycles required before system reset is released (min 1).
REQ-003 Parameter LOCK_TIMEOUT_CYC, default 65536: number of WAIT_LOCK cycles without lock before the attempt times out (min 2).
REQ-004 Parameter MAX_RETRY, default 7: number of PLL reset retries allowed before FAULT (range 0..15).
REQ-005 clk  input  1  single system clock; the only clock in the block.
REQ-006 resetn  input  1  synchronous, active-low reset from board switch SW3.
REQ-007 pll_LOCKED  input  1  PLL lock indication, asynchronous to clk.
REQ-008 pll_RSTN  output  1  active-low PLL reset.
REQ-009 sys_rstn  output  1  active-low reset to the downstream counter/GPIO logic; 1 only in RUN.
REQ-010 run  output  1  high only in RUN; equals sys_rstn.
REQ-011 fault  output  1  high only in FAULT.
REQ-012 state  output  3  current state encoding: RST_PLL=0, WAIT_LOCK=1, QUALIFY=2, RUN=3, FAULT=4.
REQ-013 retry_cnt  output  4  retries consumed in the current bring-up.
REQ-014 lock_loss_cnt  output  8  lock losses seen in RUN, saturating at 255.

Function
REQ-015 pll_LOCKED shall pass through a 2-flop synchronizer (lock_s); all decisions use lock_s only.
REQ-016 Outputs pll_RSTN, sys_rstn, run and fault shall be decoded from the registered state only: pll_RSTN=0 iff RST_PLL; sys_rstn=run=1 iff RUN; fault=1 iff FAULT.
REQ-017 A single cycle counter, sized to hold max(RST_PULSE_CYC, LOCK_STABLE_CYC, LOCK_TIMEOUT_CYC)-1, shall clear on every state change.
REQ-018 RST_PLL: stays exactly RST_PULSE_CYC cycles, then goes to WAIT_LOCK.
REQ-019 WAIT_LOCK: if lock_s=1, go to QUALIFY on the next edge; otherwise, on the LOCK_TIMEOUT_CYC-th cycle, time out.
REQ-020 On timeout: if retry_cnt==MAX_RETRY, go to FAULT; otherwise increment retry_cnt and go to RST_PLL.
REQ-021 If lock_s=1 in the final timeout cycle, lock wins: go to QUALIFY with retry_cnt unchanged.
REQ-022 QUALIFY: lock_s=0 in any cycle returns to WAIT_LOCK (timeout count restarts); after LOCK_STABLE_CYC consecutive lock_s=1 cycles, go to RUN.
REQ-023 RUN: lock_s=0 goes to RST_PLL, increments lock_loss_cnt (saturating) and clears retry_cnt.
REQ-024 FAULT is sticky regardless of pll_LOCKED; only resetn=0 exits it, and pll_RSTN=1 while in FAULT.
REQ-025 Latency: sys_rstn rises exactly LOCK_STABLE_CYC+3 cycles after a pll_LOCKED rise seen in WAIT_LOCK, and falls exactly 3 cycles after a pll_LOCKED fall in RUN.

Reset
REQ-026 While resetn=0 at a clk edge: state=RST_PLL, counter=0, retry_cnt=0, lock_loss_cnt=0, synchronizer flops=0; hence pll_RSTN=0, sys_rstn=0, run=0, fault=0.
REQ-027 After resetn goes high, pll_RSTN shall stay low exactly RST_PULSE_CYC further cycles.
REQ-028 Reset asserted in any state, including mid-QUALIFY or FAULT, shall take effect at the next edge with no pending history retained.

Structure
REQ-029 Shared package pll_seq_pkg shall hold the state encoding constants and the default parameter values; the downstream GPIO test block imports the same package.
REQ-030 The synchronizer shall be a separate sub-module sync_2ff (1-bit, reset to 0); there are no other sub-modules.

Verification (bench params: RST_PULSE_CYC=4, LOCK_STABLE_CYC=8, LOCK_TIMEOUT_CYC=32, MAX_RETRY=2)
REQ-031 Bring-up: release resetn, pll_LOCKED rises 10 cycles later -> pll_RSTN low 4 cycles; sys_rstn=1 exactly 11 cycles after the pll_LOCKED rise; retry_cnt=0.
REQ-032 Qualify glitch: pll_LOCKED drops for 3 cycles after 5 QUALIFY cycles -> state returns to 1; sys_rstn stays 0; full 8-cycle requalification before RUN.
REQ-033 No lock ever -> three 32-cycle WAIT_LOCK windows with retry_cnt 0,1,2 and 4-cycle pll_RSTN pulses between them, then state=4, fault=1; a later pll_LOCKED=1 leaves fault=1.
REQ-034 Lock loss in RUN -> sys_rstn=0 three cycles after the fall, pll_RSTN low 4 cycles, lock_loss_cnt=1, retry_cnt=0; 256 losses -> lock_loss_cnt=255.
REQ-035 Lock arriving so lock_s=1 exactly in the 32nd WAIT_LOCK cycle -> state=2 next, retry_cnt unchanged.
REQ-036 resetn low one cycle during QUALIFY, and separately during FAULT -> next cycle all outputs at reset values; bring-up then repeats as in REQ-031.
